fetch_unit: RTL and testbench

Instruction fetch stage sitting directly upstream of the `rom` instruction memory. It owns the program counter: it drives `ProgramCounter` into `rom`, captures the returned `InstructionRegister` word one cycle later, and presents each (pc, instruction) pair to the decode stage over a valid/ready handshake. It supports redirects from branch resolution and absorbs downstream back-pressure.

---
 rtl/fetch_unit.sv | 122 ++++++++++++
 tb/tb_fetch_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC owner, rom read capture, valid/ready output queue
// Optional FETCH_SKID_EN: two-entry queue with credit-based fetch instead of drop-and-replay.
module fetch_unit #(
    parameter int WORD_SIZE = 32,
    parameter int MEMORY_INDEX = 32,
    parameter logic [MEMORY_INDEX-1:0] PC_INIT_VALUE = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    output logic [MEMORY_INDEX-1:0] ProgramCounter,
    input  logic [WORD_SIZE-1:0]    InstructionRegister,
    input  logic                    redirect_valid,
    input  logic [MEMORY_INDEX-1:0] redirect_pc,
    output logic                    if_valid,
    input  logic                    if_ready,
    output logic [WORD_SIZE-1:0]    if_instr,
    output logic [MEMORY_INDEX-1:0] if_pc
);

`ifdef FETCH_SKID_EN
    localparam logic [1:0] DEPTH = 2'd2;
`else
    localparam logic [1:0] DEPTH = 2'd1;
`endif
    localparam logic [MEMORY_INDEX-1:0] PC_ONE = {{(MEMORY_INDEX-1){1'b0}}, 1'b1};

    logic [MEMORY_INDEX-1:0] pc_q, pc_d;
    logic [MEMORY_INDEX-1:0] inflight_pc_q, inflight_pc_d;
    logic                    inflight_q, inflight_d;
    logic [1:0]              occ_q, occ_d;
    logic [MEMORY_INDEX-1:0] head_pc_q, head_pc_d, skid_pc_q, skid_pc_d;
    logic [WORD_SIZE-1:0]    head_instr_q, head_instr_d, skid_instr_q, skid_instr_d;

    logic       pop;
    logic [1:0] occ_after_pop;
    logic       accept;
    logic       take;
`ifndef FETCH_SKID_EN
    logic       drop;
`endif

    assign ProgramCounter = pc_q;
    assign if_valid       = (occ_q != 2'd0);
    assign if_pc          = head_pc_q;
    assign if_instr       = head_instr_q;

    always_comb begin
        pop           = if_valid & if_ready;
        occ_after_pop = occ_q - {1'b0, pop};
        accept        = inflight_q & ~redirect_valid & (occ_after_pop < DEPTH);
`ifdef FETCH_SKID_EN
        // Only issue a read if its data is guaranteed a queue slot on arrival.
        take = ~redirect_valid & ((occ_after_pop + {1'b0, accept}) <= 2'd1);
`else
        drop = inflight_q & ~redirect_valid & ~accept;
        take = ~redirect_valid & ~drop;
`endif
    end

    always_comb begin
        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        occ_d         = occ_after_pop + {1'b0, accept};
        if (redirect_valid) begin
            pc_d  = redirect_pc;
            occ_d = 2'd0;
`ifndef FETCH_SKID_EN
        end else if (drop) begin
            // Replay the dropped word; the read of pc_q issued this cycle is killed.
            pc_d = inflight_pc_q;
`endif
        end else if (take) begin
            inflight_d    = 1'b1;
            inflight_pc_d = pc_q;
            pc_d          = pc_q + PC_ONE;
        end
    end

    always_comb begin
        head_pc_d    = head_pc_q;
        head_instr_d = head_instr_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        if (pop) begin
            head_pc_d    = skid_pc_q;
            head_instr_d = skid_instr_q;
        end
        if (accept) begin
            if (occ_after_pop == 2'd0) begin
                head_pc_d    = inflight_pc_q;
                head_instr_d = InstructionRegister;
            end else begin
                skid_pc_d    = inflight_pc_q;
                skid_instr_d = InstructionRegister;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= PC_INIT_VALUE;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            occ_q         <= 2'd0;
            head_pc_q     <= '0;
            head_instr_q  <= '0;
            skid_pc_q     <= '0;
            skid_instr_q  <= '0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            occ_q         <= occ_d;
            head_pc_q     <= head_pc_d;
            head_instr_q  <= head_instr_d;
            skid_pc_q     <= skid_pc_d;
            skid_instr_q  <= skid_instr_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed bench for fetch_unit against a registered rom where word i = i
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] ProgramCounter;
    logic [31:0] rom_q;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        if_valid;
    logic        if_ready = 1'b1;
    logic [31:0] if_instr;
    logic [31:0] if_pc;

    int vectors = 0;
    int miscompares = 0;

`ifdef FETCH_SKID_EN
    localparam int RESUME_BOUND = 1;
`else
    localparam int RESUME_BOUND = 3;
`endif

    fetch_unit #(
        .WORD_SIZE(32),
        .MEMORY_INDEX(32),
        .PC_INIT_VALUE(32'h0)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ProgramCounter(ProgramCounter),
        .InstructionRegister(rom_q),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .if_valid(if_valid),
        .if_ready(if_ready),
        .if_instr(if_instr),
        .if_pc(if_pc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_q <= ProgramCounter;

    task automatic cyc();
        @(negedge clk);
    endtask

    // Returns at the sample point of cycle 0 (rst_n just released).
    task automatic restart();
        if_ready = 1'b1;
        redirect_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_valid(input int bound, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            cyc();
            if (if_valid) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        vectors++;
        if ({if_valid, ProgramCounter, if_pc, if_instr} !== {1'b0, 32'h0, 32'h0, 32'h0}) begin
            miscompares++;
            $display("FAIL reset_state: valid=%0b pc=%h if_pc=%h if_instr=%h, want 0/0/0/0", if_valid, ProgramCounter, if_pc, if_instr);
        end
        rst_n = 1'b1;
        #1;
        vectors++;
        if ({if_valid, ProgramCounter} !== {1'b0, 32'h0}) begin
            miscompares++;
            $display("FAIL cycle0: valid=%0b pc=%h, want 0/00000000", if_valid, ProgramCounter);
        end
        cyc();
        vectors++;
        if (if_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL cycle1_valid: got %0b want 0", if_valid);
        end
        for (int i = 0; i <= 10; i++) begin
            cyc();
            vectors++;
            if ({if_valid, if_pc, if_instr} !== {1'b1, i[31:0], i[31:0]}) begin
                miscompares++;
                $display("FAIL stream_%0d: valid=%0b pc=%h instr=%h, want 1/%h/%h", i, if_valid, if_pc, if_instr, i, i);
            end
        end
    endtask

    task automatic test_async_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({if_valid, ProgramCounter} !== {1'b0, 32'h0}) begin
            miscompares++;
            $display("FAIL async_reset: valid=%0b pc=%h, want 0/00000000", if_valid, ProgramCounter);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cyc();
        cyc();
        vectors++;
        if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h0, 32'h0}) begin
            miscompares++;
            $display("FAIL restart_cycle2: valid=%0b pc=%h instr=%h, want 1/0/0", if_valid, if_pc, if_instr);
        end
        cyc();
        vectors++;
        if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h1, 32'h1}) begin
            miscompares++;
            $display("FAIL restart_cycle3: valid=%0b pc=%h instr=%h, want 1/1/1", if_valid, if_pc, if_instr);
        end
    endtask

    task automatic test_redirect();
        restart();
        repeat (10) cyc();
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        cyc();
        redirect_valid = 1'b0;
        vectors++;
        if ({if_valid, ProgramCounter} !== {1'b0, 32'h40}) begin
            miscompares++;
            $display("FAIL redirect_n1: valid=%0b pc=%h, want 0/00000040", if_valid, ProgramCounter);
        end
        cyc();
        vectors++;
        if (if_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL redirect_n2_valid: got %0b want 0 (pc=%h)", if_valid, if_pc);
        end
        for (int i = 0; i < 2; i++) begin
            automatic logic [31:0] exp = 32'h40 + i;
            cyc();
            vectors++;
            if ({if_valid, if_pc, if_instr} !== {1'b1, exp, exp}) begin
                miscompares++;
                $display("FAIL redirect_target_%0d: valid=%0b pc=%h instr=%h, want 1/%h/%h", i, if_valid, if_pc, if_instr, exp, exp);
            end
        end
    endtask

    task automatic test_redirect_pop();
        restart();
        repeat (9) cyc();
        vectors++;
        if ({if_valid, if_pc} !== {1'b1, 32'h7}) begin
            miscompares++;
            $display("FAIL pre_pop7: valid=%0b pc=%h, want 1/00000007", if_valid, if_pc);
        end
        redirect_valid = 1'b1;
        redirect_pc = 32'h20;
        cyc();
        redirect_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (if_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL pop_redirect_bubble_%0d: valid=%0b pc=%h, want valid 0", i, if_valid, if_pc);
            end
            cyc();
        end
        vectors++;
        if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h20, 32'h20}) begin
            miscompares++;
            $display("FAIL pop_redirect_next: valid=%0b pc=%h instr=%h, want 1/20/20", if_valid, if_pc, if_instr);
        end
    endtask

    task automatic test_stall();
        bit seen;
        restart();
        repeat (7) cyc();
        vectors++;
        if ({if_valid, if_pc} !== {1'b1, 32'h5}) begin
            miscompares++;
            $display("FAIL pre_stall: valid=%0b pc=%h, want 1/00000005", if_valid, if_pc);
        end
        if_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            vectors++;
            if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h5, 32'h5}) begin
                miscompares++;
                $display("FAIL stall_hold_%0d: valid=%0b pc=%h instr=%h, want 1/5/5", i, if_valid, if_pc, if_instr);
            end
        end
        if_ready = 1'b1;
        for (int i = 6; i <= 9; i++) begin
            wait_valid(RESUME_BOUND, seen);
            vectors++;
            if (!seen || if_pc !== i[31:0] || if_instr !== i[31:0]) begin
                miscompares++;
                $display("FAIL resume_%0d: seen=%0b pc=%h instr=%h, want pc/instr %h within %0d cycles", i, seen, if_pc, if_instr, i, RESUME_BOUND);
            end
        end
    endtask

    task automatic test_wrap();
        restart();
        repeat (4) cyc();
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFF;
        cyc();
        redirect_valid = 1'b0;
        vectors++;
        if (ProgramCounter !== 32'hFFFF_FFFF) begin
            miscompares++;
            $display("FAIL wrap_pc: got %h want ffffffff", ProgramCounter);
        end
        cyc();
        for (int i = 0; i < 3; i++) begin
            automatic logic [31:0] exp = 32'hFFFF_FFFF + i;
            cyc();
            vectors++;
            if ({if_valid, if_pc, if_instr} !== {1'b1, exp, exp}) begin
                miscompares++;
                $display("FAIL wrap_%0d: valid=%0b pc=%h instr=%h, want 1/%h/%h", i, if_valid, if_pc, if_instr, exp, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_async_reset();
        test_redirect();
        test_redirect_pop();
        test_stall();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
        $fatal(1);
    end

endmodule
